// File: rtl/board_insert_sequencer.sv
`timescale 1ns/1ps
// board_insert_sequencer
// Owns the single port of the Connect-4 board RAM (ROWS x COLS cells, 2 bits each).
// Drops pieces by gravity (scan a column bottom-up, write the first empty cell), clears
// the whole board, and lends the port to an external reader while idle.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   ins_req/ins_col/ins_player     insert request (level) and its column / piece value
//   ins_ack/ins_row/ins_full/ins_err  insert completion pulse and result flags
//   clr_req/clr_done               board clear request (level) and completion pulse
//   busy                           high whenever an operation is in progress
//   rd_req/rd_addr/rd_gnt          external read request, address, same-cycle grant
//   rd_valid/rd_data               read return, one cycle after the grant
//   mem_addr/mem_we/mem_wdata      board RAM command port
//   mem_rdata                      board RAM read data, one cycle after mem_addr
module board_insert_sequencer #(
    parameter int unsigned ROWS   = 6,
    parameter int unsigned COLS   = 7,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_req,
    input  logic [2:0]        ins_col,
    input  logic [1:0]        ins_player,
    output logic              ins_ack,
    output logic [2:0]        ins_row,
    output logic              ins_full,
    output logic              ins_err,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [1:0]        rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata
);

    localparam int unsigned       CELLS    = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS - 1);
    localparam logic [2:0]        LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        FULL  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t            state;
    logic [2:0]        col_q;
    logic [2:0]        row_q;
    logic [1:0]        player_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] cell_addr;
    logic              ins_ok;

    // Cell address of the latched column at the current scan row.
    assign cell_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

    assign ins_ok = (32'(ins_col) < COLS) && (ins_player == 2'd1 || ins_player == 2'd2);

    // External reads only get the port in a fully idle cycle with no pending operation.
    assign rd_gnt = (state == IDLE) && !clr_req && !ins_req && rd_req;

    assign busy = (state != IDLE);

    // RAM returns data one cycle after the grant, so it is forwarded while rd_valid is high.
    assign rd_data = rd_valid ? mem_rdata : 2'd0;

    // RAM command decode from the current state.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 2'd0;
        case (state)
            IDLE:  if (rd_gnt) mem_addr = rd_addr;
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = idx_q;
            end
            READ:  mem_addr = cell_addr;
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = cell_addr;
                mem_wdata = player_q;
            end
            default: ;
        endcase
    end

    // Sequencer state and registered result outputs; result flags are set on entry to
    // DONE/FULL/ERR so they are visible exactly while in those states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            col_q    <= 3'd0;
            row_q    <= 3'd0;
            player_q <= 2'd0;
            idx_q    <= '0;
            ins_ack  <= 1'b0;
            ins_row  <= 3'd0;
            ins_full <= 1'b0;
            ins_err  <= 1'b0;
            clr_done <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            ins_ack  <= 1'b0;
            ins_row  <= 3'd0;
            ins_full <= 1'b0;
            ins_err  <= 1'b0;
            clr_done <= 1'b0;
            rd_valid <= rd_gnt;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        idx_q <= '0;
                        state <= CLEAR;
                    end else if (ins_req) begin
                        col_q    <= ins_col;
                        player_q <= ins_player;
                        row_q    <= 3'd0;
                        if (ins_ok) begin
                            state <= READ;
                        end else begin
                            state   <= ERR;
                            ins_ack <= 1'b1;
                            ins_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (idx_q == LAST_IDX) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    if (mem_rdata == 2'd0) begin
                        state <= WRITE;
                    end else if (row_q != LAST_ROW) begin
                        row_q <= row_q + 3'd1;
                        state <= READ;
                    end else begin
                        state    <= FULL;
                        ins_ack  <= 1'b1;
                        ins_full <= 1'b1;
                    end
                end
                WRITE: begin
                    state   <= DONE;
                    ins_ack <= 1'b1;
                    ins_row <= row_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_insert_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for board_insert_sequencer: drivers push expected events (RAM writes,
// insert acks, clear completion, read returns) with their cycle; a monitor pops and checks.
module tb_board_insert_sequencer;

    localparam int ROWS   = 6;
    localparam int COLS   = 7;
    localparam int ADDR_W = 6;

    localparam int EV_WR  = 1;
    localparam int EV_ACK = 2;
    localparam int EV_CLR = 3;
    localparam int EV_RD  = 4;

    localparam int K_OK   = 0;
    localparam int K_FULL = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ins_req = 1'b0;
    logic [2:0]        ins_col = 3'd0;
    logic [1:0]        ins_player = 2'd0;
    logic              ins_ack;
    logic [2:0]        ins_row;
    logic              ins_full;
    logic              ins_err;
    logic              clr_req = 1'b0;
    logic              clr_done;
    logic              busy;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_gnt;
    logic              rd_valid;
    logic [1:0]        rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [1:0]        mem_wdata;
    logic [1:0]        mem_rdata = 2'd0;

    logic [1:0] ram [0:63];

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    board_insert_sequencer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ins_req(ins_req), .ins_col(ins_col), .ins_player(ins_player),
        .ins_ack(ins_ack), .ins_row(ins_row), .ins_full(ins_full), .ins_err(ins_err),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            EV_WR:   return "wr";
            EV_ACK:  return "ack";
            EV_CLR:  return "clr_done";
            EV_RD:   return "rd";
            default: return "none";
        endcase
    endfunction

    task automatic push(input int k, input int a, input int b, input int c, input int cy);
        exp_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.cyc = cy;
        q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int a, input int b, input int c);
        exp_t e;
        if (q.size() == 0) begin
            chk({"unexpected_", kname(kind)}, kind, 0);
            return;
        end
        e = q.pop_front();
        chk({kname(e.kind), "_kind"}, kind, e.kind);
        chk({kname(e.kind), "_a"}, a, e.a);
        chk({kname(e.kind), "_b"}, b, e.b);
        chk({kname(e.kind), "_c"}, c, e.c);
        chk({kname(e.kind), "_cycle"}, cyc, e.cyc);
    endtask

    // Monitor: one sample per cycle, away from the rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we) got_ev(EV_WR, int'(mem_addr), int'(mem_wdata), 0);
        if (ins_ack) got_ev(EV_ACK, int'(ins_row), int'(ins_full), int'(ins_err));
        else chk("flags_without_ack", int'({ins_row, ins_full, ins_err}), 0);
        if (clr_done) got_ev(EV_CLR, 0, 0, 0);
        if (rd_valid) got_ev(EV_RD, int'(rd_data), 0, 0);
    end

    task automatic start_cycle(output int t0);
        @(negedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic wait_ack(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (ins_ack) seen = 1'b1;
        end
        ins_req = 1'b0;
        chk({nm, "_ack_seen"}, int'(seen), 1);
    endtask

    // Insert with hand-computed result: kind, landing row/address and ack latency.
    task automatic insert(input int col, input int pl, input int kind, input int row,
                          input int addr, input int lat);
        int t0;
        start_cycle(t0);
        if (kind == K_OK) begin
            push(EV_WR, addr, pl, 0, t0 + lat - 1);
            push(EV_ACK, row, 0, 0, t0 + lat);
        end else if (kind == K_FULL) begin
            push(EV_ACK, 0, 1, 0, t0 + lat);
        end else begin
            push(EV_ACK, 0, 0, 1, t0 + lat);
        end
        ins_col    = 3'(col);
        ins_player = 2'(pl);
        ins_req    = 1'b1;
        wait_ack($sformatf("ins_c%0d_p%0d", col, pl));
    endtask

    task automatic do_read(input int addr, input int want);
        int t0;
        start_cycle(t0);
        push(EV_RD, want, 0, 0, t0 + 1);
        rd_addr = ADDR_W'(addr);
        rd_req  = 1'b1;
        #1;
        chk("rd_gnt_idle", int'(rd_gnt), 1);
        chk("rd_mem_addr", int'(mem_addr), addr);
        @(negedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    initial begin
        int  t0;
        bit  seen;
        for (int i = 0; i < 64; i++) ram[i] = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", int'({ins_ack, ins_row, ins_full, ins_err, clr_done, busy, rd_gnt,
                                   rd_valid, rd_data, mem_addr, mem_we, mem_wdata}), 0);
        rst = 1'b1;

        // Empty column 3: lands on row 0, ack at 4
        insert(3, 1, K_OK, 0, 3, 4);
        // Stack column 3 up to row 3: ack at 4+2r
        insert(3, 2, K_OK, 1, 10, 6);
        insert(3, 1, K_OK, 2, 17, 8);
        insert(3, 2, K_OK, 3, 24, 10);

        // Full column 6: no write, ack at 13
        ram[6] = 2'd1; ram[13] = 2'd2; ram[20] = 2'd1;
        ram[27] = 2'd2; ram[34] = 2'd1; ram[41] = 2'd2;
        insert(6, 1, K_FULL, 0, 0, 13);
        do_read(41, 2);
        do_read(6, 1);
        do_read(24, 2);

        // Illegal column / player: error at 1, no access
        insert(7, 1, K_ERR, 0, 0, 1);
        insert(2, 0, K_ERR, 0, 0, 1);
        insert(2, 3, K_ERR, 0, 0, 1);
        do_read(2, 0);

        // Clear and insert together: clear wins, then the held insert runs
        start_cycle(t0);
        for (int i = 0; i < ROWS * COLS; i++) push(EV_WR, i, 0, 0, t0 + 1 + i);
        push(EV_CLR, 0, 0, 0, t0 + 43);
        push(EV_WR, 0, 2, 0, t0 + 47);
        push(EV_ACK, 0, 0, 0, t0 + 48);
        ins_col = 3'd0; ins_player = 2'd2;
        clr_req = 1'b1; ins_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (clr_done) seen = 1'b1;
        end
        clr_req = 1'b0;
        chk("clr_done_seen", int'(seen), 1);
        wait_ack("ins_after_clear");

        // Idle reads after clear
        do_read(0, 2);
        do_read(10, 0);
        do_read(41, 0);

        // Read held during an insert: no grant until idle
        start_cycle(t0);
        push(EV_WR, 1, 1, 0, t0 + 3);
        push(EV_ACK, 0, 0, 0, t0 + 4);
        push(EV_RD, 1, 0, 0, t0 + 6);
        ins_col = 3'd1; ins_player = 2'd1; ins_req = 1'b1;
        rd_addr = ADDR_W'(1); rd_req = 1'b1;
        #1;
        chk("rd_gnt_with_ins_req", int'(rd_gnt), 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (ins_ack) seen = 1'b1;
            else begin
                chk("rd_gnt_busy", int'(rd_gnt), 0);
                chk("busy_during_ins", int'(busy), 1);
            end
        end
        ins_req = 1'b0;
        chk("rd_ins_ack_seen", int'(seen), 1);
        @(negedge clk);
        #1;
        chk("rd_gnt_after_ins", int'(rd_gnt), 1);
        chk("busy_after_ins", int'(busy), 0);
        @(negedge clk);
        #1;
        rd_req = 1'b0;

        // Reset mid-clear: ten cells written, then everything back to idle
        start_cycle(t0);
        for (int i = 0; i < 10; i++) push(EV_WR, i, 0, 0, t0 + 1 + i);
        clr_req = 1'b1;
        @(negedge clk);
        #1;
        clr_req = 1'b0;
        repeat (9) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_mid_clear_outputs", int'({ins_ack, ins_row, ins_full, ins_err, clr_done, busy,
                                             rd_gnt, rd_valid, rd_data, mem_addr, mem_we,
                                             mem_wdata}), 0);
        rst = 1'b1;
        do_read(0, 0);
        do_read(1, 0);
        insert(1, 2, K_OK, 0, 1, 4);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d expected events pending", q.size());
        $fatal(1, "watchdog");
    end

endmodule
